// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's-complement; result WIDTH cycles after accept.
// One operation in flight: in_ready only in IDLE, product held in DONE until out_ready.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A0,
  input  logic [WIDTH-1:0]   B0,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] C0,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_signed;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_c0;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [2*WIDTH-1:0]   w_pp;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_sum;

  // In signed mode the MSB of the multiplier has weight -2^(W-1), so its partial product is subtracted.
  assign w_pp   = r_b[0] ? r_a : '0;
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_sum  = (w_last && r_signed) ? (r_acc - w_pp) : (r_acc + w_pp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_signed    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_c0        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= signed_mode ? {{WIDTH{A0[WIDTH-1]}}, A0} : {{WIDTH{1'b0}}, A0};
            r_b        <= B0;
            r_signed   <= signed_mode;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_acc <= w_sum;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_c0        <= w_sum;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign C0        = r_c0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: W=4 instance checked every cycle against a behavioural model,
// W=8 instance checked per operation; directed literal cases pin the model.
module tb_shift_add_multiplier;
  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [3:0] A0, B0;
  logic [7:0] C0;

  logic        in_valid_8, in_ready_8, signed_mode_8, out_valid_8, out_ready_8, busy_8;
  logic [7:0]  A0_8, B0_8;
  logic [15:0] C0_8;

  int n_checks = 0;
  int n_errors = 0;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A0(A0), .B0(B0),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .C0(C0), .busy(busy));

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .A0(A0_8), .B0(B0_8),
    .signed_mode(signed_mode_8), .out_valid(out_valid_8), .out_ready(out_ready_8), .C0(C0_8),
    .busy(busy_8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Exact product by plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int w);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Behavioural model of the W=4 instance: 0 idle, 1 computing, 2 result waiting.
  int         m_state = 0;
  int         m_left = 0;
  logic [7:0] m_prod = '0;
  logic [7:0] m_c0 = '0;
  bit         chk_en = 1'b0;
  int         cyc = 0;
  int         acc_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_state <= 0;
      m_c0    <= '0;
      chk_en  <= 1'b1;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_prod  <= 8'(ref_mul(64'(A0), 64'(B0), signed_mode, 4));
          m_left  <= 4;
          m_state <= 1;
          acc_cyc.push_back(cyc);
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_state <= 2;
            m_c0    <= m_prod;
          end
        end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_state == 2));
      chk("in_ready", 64'(in_ready), 64'(m_state == 0));
      chk("busy", 64'(busy), 64'(m_state == 1));
      chk("C0", 64'(C0), 64'(m_c0));
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [7:0] exp, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; A0 = a; B0 = b; signed_mode = s; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A0 = 4'($urandom); B0 = 4'($urandom); signed_mode = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_C0"}, 64'(C0), 64'(exp));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string nm);
    int n;
    @(negedge clk);
    in_valid_8 = 1'b1; A0_8 = a; B0_8 = b; signed_mode_8 = s; out_ready_8 = 1'b1;
    @(negedge clk);
    in_valid_8 = 1'b0; A0_8 = 8'($urandom); B0_8 = 8'($urandom);
    n = 0;
    while (!out_valid_8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_C0"}, 64'(C0_8), 64'(exp));
  endtask

  initial begin
    int base;
    logic [7:0] held;
    logic [7:0] ra, rb;
    logic       rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A0 = '0; B0 = '0; signed_mode = 1'b0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0; A0_8 = '0; B0_8 = '0; signed_mode_8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_C0", 64'(C0), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_C0_w8", 64'(C0_8), 64'd0);
    rst = 1'b0;

    op4(4'b0110, 4'b0110, 1'b0, 8'h24, "u6x6");

    base = acc_cyc.size();
    op4(4'd7, 4'd5, 1'b0, 8'h23, "b2b_7x5");
    op4(4'd7, 4'd7, 1'b0, 8'h31, "b2b_7x7");
    op4(4'd7, 4'd3, 1'b0, 8'h15, "b2b_7x3");
    if (acc_cyc.size() >= base + 3) begin
      chk("b2b_gap1", 64'(acc_cyc[base+1] - acc_cyc[base]), 64'd6);
      chk("b2b_gap2", 64'(acc_cyc[base+2] - acc_cyc[base+1]), 64'd6);
    end else begin
      chk("b2b_accepts", 64'(acc_cyc.size() - base), 64'd3);
    end

    op4(4'hD, 4'h5, 1'b1, 8'hF1, "s_m3x5");
    op4(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
    op4(4'h7, 4'hF, 1'b1, 8'hF9, "s_7xm1");
    op4(4'hF, 4'hF, 1'b0, 8'hE1, "u_15x15");

    // Backpressure: result held for 10 cycles while stray in_valid pulses arrive.
    @(negedge clk);
    in_valid = 1'b1; A0 = 4'd3; B0 = 4'd5; signed_mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_valid_start", 64'(out_valid), 64'd1);
    held = C0;
    chk("bp_C0_start", 64'(held), 64'd15);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); A0 = 4'($urandom); B0 = 4'($urandom);
      @(negedge clk);
      chk("bp_C0_hold", 64'(C0), 64'(held));
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Reset during the 2nd computing cycle discards the operation.
    in_valid = 1'b1; A0 = 4'd5; B0 = 4'd5; signed_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_C0", 64'(C0), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", 64'(out_valid), 64'd0);
    end
    op4(4'd2, 4'd6, 1'b0, 8'h0C, "after_rst_2x6");

    op8(8'd255, 8'd255, 1'b0, 16'hFE01, "w8_255x255");
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8_m128x127");
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      op8(ra, rb, rs, 16'(ref_mul(64'(ra), 64'(rb), rs, 8)), "w8_rand");
    end

    // Random traffic on the W=4 instance; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      in_valid    = 1'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      A0          = 4'($urandom);
      B0          = 4'($urandom);
      signed_mode = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands A0/B0/signed_mode are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port A0, input, WIDTH bits: the multiplicand.
REQ-007 The block SHALL have port B0, input, WIDTH bits: the multiplier.
REQ-008 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: C0 holds a completed product.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts C0.
REQ-011 The block SHALL have port C0, output, 2*WIDTH bits: the product.
REQ-012 The block SHALL have port busy, output, 1 bit: a multiplication is in progress.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-015 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; on an accept, the block SHALL latch A0, B0 and signed_mode, clear the accumulator and bit counter, and go to CALC.
REQ-016 Operand and mode changes after the accept edge SHALL have no effect on the in-flight product.
REQ-017 CALC SHALL last exactly WIDTH cycles, one multiplier bit per cycle, LSB first, via shift-add; there is no early termination on zero operands.
REQ-018 On the WIDTH-th edge after the accept, the block SHALL enter DONE with out_valid=1 and C0 = final product; latency is fixed at WIDTH cycles, accept edge to out_valid.
REQ-019 busy SHALL be 1 exactly while in CALC.
REQ-020 Unsigned mode: C0 SHALL equal A0*B0 zero-extended, exact in 2*WIDTH bits.
REQ-021 Signed mode: C0 SHALL equal the two's-complement product in 2*WIDTH bits; this includes the case most-negative * most-negative (e.g. W=4: -8*-8 = 0x40), which SHALL be exact with no overflow.
REQ-022 The implementation method for signed mode (correction of the last partial product, or Baugh-Wooley) SHALL produce results that are indistinguishable at the ports.
REQ-023 In DONE, C0 and out_valid SHALL be held stable while out_ready=0, for any number of cycles.
REQ-024 In DONE with out_ready=1, the next edge SHALL return the block to IDLE with out_valid=0; C0 SHALL retain the last product until the next result.
REQ-025 An accept SHALL NOT occur in the same cycle as an output handshake, because in_ready=0 in DONE; the minimum issue interval is WIDTH+2 cycles.
REQ-026 When out_ready=1 in IDLE or CALC, it SHALL have no effect.

Reset
REQ-027 When rst=1 on an edge, the block SHALL go to IDLE with out_valid=0, busy=0, C0=0, and the accumulator, counter and latched operands all 0.
REQ-028 After that edge, in_ready SHALL be 1.
REQ-029 rst SHALL take priority over any simultaneous accept or output handshake.
REQ-030 rst asserted in CALC or DONE SHALL abort the operation and discard its result; no out_valid SHALL follow.

Verification
REQ-031 W=4, unsigned, A0=0110, B0=0110, out_ready=1 -> out_valid 4 cycles after accept, C0=0x24 (36); IDLE the next cycle.
REQ-032 W=4, unsigned, back-to-back: 7*5 then 7*7 then 7*3 -> C0=0x23, 0x31, 0x15, with consecutive accepts 6 cycles apart.
REQ-033 W=4, signed: -3*5 -> C0=0xF1; -8*-8 -> C0=0x40; 7*-1 -> C0=0xF9; unsigned 1111*1111 -> C0=0xE1.
REQ-034 Backpressure: out_ready held 0 for 10 cycles after out_valid -> C0 and out_valid stable throughout, in_ready=0 throughout, and in_valid pulses during that time are ignored.
REQ-035 Reset mid-operation: rst on the 2nd CALC cycle -> the next cycle shows IDLE, C0=0, busy=0, in_ready=1, and no out_valid; a following 2*6 SHALL yield C0=0x0C.
REQ-036 W=8, unsigned, 255*255 -> C0=0xFE01 after 8 cycles; signed, -128*127 -> C0=0xC080.
